pc_fetch_ctrl: RTL and testbench

Program-counter and fetch-control block at the front of the pipeline; it consumes the next-PC targets produced in ID and turns them into the actual fetch address stream. Holds the architectural PC, advances it by 4, applies taken branch/jump/jr redirects, honours hazard stalls and instruction-memory back-pressure, and flushes the wrong-path instruction in IF/ID. Redirects that cannot be applied immediately are held in a one-entry pending register.

---
 rtl/pc_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC and fetch control: sequential advance, ID redirects, stall/back-pressure hold, one-entry pending redirect.
// Optional feature: define PC_ALIGN_CHECK_EN to force applied targets word-aligned and flag misalign_o.
module pc_fetch_ctrl #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic              redirect_sel_i,
  input  logic [DATA_W-1:0] npc_target_i,
  input  logic [DATA_W-1:0] gpr_target_i,
  input  logic              imem_ready_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_add4_o,
  output logic              if_valid_o,
  output logic              flush_o,
  output logic              pend_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] pend_tgt_p0;
  logic              pend_vld_p0;
  logic [DATA_W-1:0] tgt;
  logic [DATA_W-1:0] raw_next;
  logic [DATA_W-1:0] pc_next;
  logic              adv;
  logic              redirect_apply;

  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return {a[DATA_W-1:2], 2'b00};
`else
    return a;
`endif
  endfunction

  // No fetch is presented in BOOT, so nothing can advance there.
  assign adv            = (state_q != BOOT) && !stall_i && imem_ready_i;
  assign tgt            = redirect_sel_i ? gpr_target_i : npc_target_i;
  assign redirect_apply = adv && (redirect_valid_i || pend_vld_p0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!adv) state_d = HOLD;
      HOLD:    if (adv) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    raw_next = pc_p0;
    pc_next  = pc_p0;
    if (adv) begin
      if (redirect_valid_i) begin
        raw_next = tgt;
        pc_next  = align_pc(tgt);
      end else if (pend_vld_p0) begin
        raw_next = pend_tgt_p0;
        pc_next  = align_pc(pend_tgt_p0);
      end else begin
        raw_next = pc_p0 + DATA_W'(4);
        pc_next  = raw_next;
      end
    end
  end

  // Stage p0: architectural PC, FSM state and pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_p0       <= RESET_PC;
      pend_vld_p0 <= 1'b0;
      pend_tgt_p0 <= '0;
    end else begin
      state_q <= state_d;
      pc_p0   <= pc_next;
      if (redirect_apply) begin
        pend_vld_p0 <= 1'b0;
      end else if (redirect_valid_i) begin
        pend_vld_p0 <= 1'b1;
        pend_tgt_p0 <= tgt;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_p0 <= 1'b0;
    end else begin
      misalign_p0 <= redirect_apply && (raw_next[1:0] != 2'b00);
    end
  end

  assign misalign_o = misalign_p0;
`else
  assign misalign_o = 1'b0;
`endif

  assign pc_o       = pc_p0;
  assign pc_add4_o  = pc_p0 + DATA_W'(4);
  assign if_valid_o = (state_q != BOOT);
  assign flush_o    = redirect_apply;
  assign pend_o     = pend_vld_p0;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed table-driven bench for pc_fetch_ctrl plus hand sequences for reset and boot-time redirects.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic        redirect_sel_i = 1'b0;
  logic [31:0] npc_target_i = '0;
  logic [31:0] gpr_target_i = '0;
  logic        imem_ready_i = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] pc_add4_o;
  logic        if_valid_o;
  logic        flush_o;
  logic        pend_o;
  logic        misalign_o;

  int passed = 0;
  int total  = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC   = 32'h0000_3040;
  localparam logic        MIS_FLAG = 1'b1;
`else
  localparam logic [31:0] MIS_PC   = 32'h0000_3042;
  localparam logic        MIS_FLAG = 1'b0;
`endif

  typedef struct {
    logic        stall;
    logic        rv;
    logic        sel;
    logic        rdy;
    logic [31:0] npc;
    logic [31:0] gpr;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_pend;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  pc_fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_sel_i   (redirect_sel_i),
    .npc_target_i     (npc_target_i),
    .gpr_target_i     (gpr_target_i),
    .imem_ready_i     (imem_ready_i),
    .pc_o             (pc_o),
    .pc_add4_o        (pc_add4_o),
    .if_valid_o       (if_valid_o),
    .flush_o          (flush_o),
    .pend_o           (pend_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic stall, rv, sel, rdy, input logic [31:0] npc, gpr, e_pc,
                              input logic e_flush, e_pend, e_valid, e_mis);
    vec_t v;
    v.stall = stall; v.rv = rv; v.sel = sel; v.rdy = rdy;
    v.npc = npc; v.gpr = gpr; v.e_pc = e_pc;
    v.e_flush = e_flush; v.e_pend = e_pend; v.e_valid = e_valid; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic stall, rv, sel, rdy, input logic [31:0] npc, gpr);
    stall_i = stall; redirect_valid_i = rv; redirect_sel_i = sel;
    imem_ready_i = rdy; npc_target_i = npc; gpr_target_i = gpr;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc,
                            input logic e_flush, e_pend, e_valid, e_mis);
    chk({tag, " pc_o"}, pc_o, e_pc);
    chk({tag, " pc_add4_o"}, pc_add4_o, e_pc + 32'd4);
    chk({tag, " flush_o"}, {31'd0, flush_o}, {31'd0, e_flush});
    chk({tag, " pend_o"}, {31'd0, pend_o}, {31'd0, e_pend});
    chk({tag, " if_valid_o"}, {31'd0, if_valid_o}, {31'd0, e_valid});
    chk({tag, " misalign_o"}, {31'd0, misalign_o}, {31'd0, e_mis});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        stall rv sel rdy npc            gpr            pc             fl pd vl mis
    vecs[0]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3000, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3004, 0, 0, 1, 0);
    vecs[3]  = mk(0, 1, 0, 1, 32'h0000_3040, 32'h0,         32'h0000_3008, 1, 0, 1, 0);
    vecs[4]  = mk(1, 1, 1, 1, 32'h0,         32'h0000_3100, 32'h0000_3040, 0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3040, 0, 1, 1, 0);
    vecs[6]  = mk(1, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3040, 0, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3040, 1, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3100, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0000_3200, 32'h0,         32'h0000_3104, 0, 0, 1, 0);
    vecs[10] = mk(0, 1, 0, 0, 32'h0000_3300, 32'h0,         32'h0000_3104, 0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3104, 0, 1, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3104, 1, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_3300, 0, 0, 1, 0);
    vecs[14] = mk(0, 1, 1, 1, 32'h0000_5000, 32'hFFFF_FFFC, 32'h0000_3304, 1, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'hFFFF_FFFC, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 32'h0,         32'h0,         32'h0000_0000, 0, 0, 1, 0);
    vecs[17] = mk(0, 1, 0, 1, 32'h0000_3042, 32'h0,         32'h0000_0004, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 1, 32'h0,         32'h0,         MIS_PC,        0, 0, 1, MIS_FLAG);
    vecs[19] = mk(0, 0, 0, 1, 32'h0,         32'h0,         MIS_PC + 32'd4, 0, 0, 1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 32'h0000_3000, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].sel, vecs[i].rdy, vecs[i].npc, vecs[i].gpr);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush, vecs[i].e_pend,
                 vecs[i].e_valid, vecs[i].e_mis);
      @(posedge clk);
      #1;
    end

    // Pending redirect discarded by asynchronous reset mid-cycle
    drive(1, 1, 0, 1, 32'h0000_3400, 32'h0);
    @(posedge clk);
    #1;
    drive(1, 0, 0, 1, 32'h0, 32'h0);
    #2;
    chk("pend before reset", {31'd0, pend_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset pend_o", {31'd0, pend_o}, 32'd0);
    chk("async reset pc_o", pc_o, 32'h0000_3000);
    chk("async reset if_valid_o", {31'd0, if_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Redirect arriving during BOOT is held, then applied on the first FETCH cycle
    drive(0, 1, 0, 1, 32'h0000_3500, 32'h0);
    #2;
    check_outs("boot redirect", 32'h0000_3000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    #2;
    check_outs("boot apply", 32'h0000_3000, 1, 1, 1, 0);
    @(posedge clk);
    #1;
    check_outs("boot target", 32'h0000_3500, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check_outs("boot seq", 32'h0000_3504, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
